// File: rtl/board_pkg.sv
// Shared types and constants for the board memory and its arbiter.
package board_pkg;

  typedef logic [7:0] cell_t;
  typedef logic [9:0] board_addr_t;

  localparam int    BOARD_DIM   = 32;
  localparam cell_t CELL_EMPTY  = 8'd35;
  localparam cell_t CELL_FILLED = 8'd32;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_CLEAR  = 1'b1
  } arb_state_t;

  // One queued write: target cell address and the code to store there.
  typedef struct packed {
    board_addr_t addr;
    cell_t       data;
  } wr_entry_t;

  function automatic board_addr_t cell_addr(input logic [4:0] row, input logic [4:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/board_ram.sv
// 1024x8 single-port board memory; synchronous read and write, contents not reset.
module board_ram
  import board_pkg::*;
(
  input  logic        clk,
  input  logic        i_we,
  input  logic        i_re,
  input  board_addr_t i_addr,
  input  cell_t       i_wdata,
  output cell_t       o_rdata
);

  cell_t r_mem [1024];
  cell_t r_rdata;

  // One access per cycle; a write takes precedence over a read.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/board_mem_arbiter.sv
// Board memory arbiter: display reads have priority, buffered game-logic writes
// and full-board clears share the remaining slots, and a run counter bounds how
// long the display can starve them.
// Optional macro BOARD_ARB_STATS_EN enables the saturating display-stall counter;
// without it stall_cnt is tied to zero.
//
// state     | meaning
// ST_NORMAL | spare slots drain the write FIFO
// ST_CLEAR  | spare slots sweep CLEAR_CODE over 0..1023; FIFO holds its entries
module board_mem_arbiter
  import board_pkg::*;
#(
  parameter int unsigned MAX_DISP_RUN = 8,
  parameter int unsigned WQ_DEPTH     = 4,
  parameter cell_t       CLEAR_CODE   = 8'd35
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        disp_req,
  input  logic [4:0]  disp_row,
  input  logic [4:0]  disp_col,
  output logic        disp_gnt,
  output logic        disp_valid,
  output cell_t       disp_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [4:0]  wr_row,
  input  logic [4:0]  wr_col,
  input  cell_t       wr_data,
  input  logic        clr_start,
  output logic        clr_busy,
  output logic [15:0] stall_cnt
);

  localparam int         AW      = $clog2(WQ_DEPTH);
  localparam logic [7:0] RUN_MAX = 8'(MAX_DISP_RUN);
  localparam logic [AW:0] WQ_FULL = (AW+1)'(WQ_DEPTH);

  arb_state_t  r_state, w_state_nxt;
  wr_entry_t   r_wq [WQ_DEPTH];
  logic [AW-1:0] r_wq_wptr, r_wq_rptr;
  logic [AW:0] r_wq_count, w_wq_count_nxt;
  logic        r_wr_ready;
  logic        r_disp_valid;
  logic [7:0]  r_run_cnt;
  board_addr_t r_clr_addr;

  logic        w_pending, w_other_slot, w_push, w_pop, w_sweep;
  board_addr_t w_ram_addr;
  cell_t       w_ram_wdata, w_ram_rdata;

  // Slot arbitration, FIFO bookkeeping and memory port steering.
  always_comb begin
    w_pending    = (r_state == ST_CLEAR) || (r_wq_count != '0);
    disp_gnt     = disp_req && !(w_pending && (r_run_cnt == RUN_MAX));
    w_other_slot = w_pending && !disp_gnt;
    w_pop        = w_other_slot && (r_state == ST_NORMAL);
    w_sweep      = w_other_slot && (r_state == ST_CLEAR);
    w_push       = wr_valid && r_wr_ready;

    w_wq_count_nxt = r_wq_count;
    if (w_push && !w_pop) begin
      w_wq_count_nxt = r_wq_count + 1'b1;
    end else if (w_pop && !w_push) begin
      w_wq_count_nxt = r_wq_count - 1'b1;
    end

    w_ram_addr  = cell_addr(disp_row, disp_col);
    w_ram_wdata = r_wq[r_wq_rptr].data;
    if (w_sweep) begin
      w_ram_addr  = r_clr_addr;
      w_ram_wdata = CLEAR_CODE;
    end else if (w_pop) begin
      w_ram_addr = r_wq[r_wq_rptr].addr;
    end
  end

  // Next-state logic: a clear exits right after its write to the last cell.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_NORMAL: if (clr_start) w_state_nxt = ST_CLEAR;
      ST_CLEAR:  if (w_sweep && (r_clr_addr == '1)) w_state_nxt = ST_NORMAL;
    endcase
  end

  // State, sweep address, starvation counter, FIFO pointers and read-valid flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_NORMAL;
      r_clr_addr   <= '0;
      r_run_cnt    <= '0;
      r_wq_wptr    <= '0;
      r_wq_rptr    <= '0;
      r_wq_count   <= '0;
      r_wr_ready   <= 1'b1;
      r_disp_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_NORMAL) begin
        r_clr_addr <= '0;
      end else if (w_sweep) begin
        r_clr_addr <= r_clr_addr + 10'd1;
      end
      if (!w_pending || w_other_slot) begin
        r_run_cnt <= '0;
      end else if (disp_gnt) begin
        r_run_cnt <= r_run_cnt + 8'd1;
      end
      if (w_push) r_wq_wptr <= r_wq_wptr + 1'b1;
      if (w_pop)  r_wq_rptr <= r_wq_rptr + 1'b1;
      r_wq_count   <= w_wq_count_nxt;
      r_wr_ready   <= (w_wq_count_nxt < WQ_FULL);
      r_disp_valid <= disp_gnt;
    end
  end

  // FIFO storage needs no reset; only entries behind the write pointer are read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_wq[r_wq_wptr] <= '{addr: cell_addr(wr_row, wr_col), data: wr_data};
    end
  end

  board_ram u_ram (
    .clk     (clk),
    .i_we    (w_other_slot),
    .i_re    (disp_gnt),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

`ifdef BOARD_ARB_STATS_EN
  logic [15:0] r_stall_cnt;

  // Count cycles where the display asked but was held off, saturating.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (disp_req && !disp_gnt && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

  assign wr_ready   = r_wr_ready;
  assign clr_busy   = (r_state == ST_CLEAR);
  assign disp_valid = r_disp_valid;
  assign disp_data  = r_disp_valid ? w_ram_rdata : '0;

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Directed bench for board_mem_arbiter: reset values, write/read, display
// priority and starvation slots, FIFO full, clears and reset mid-clear.
module tb_board_mem_arbiter;
  import board_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        disp_req = 1'b0;
  logic [4:0]  disp_row = '0, disp_col = '0;
  logic        disp_gnt, disp_valid;
  logic [7:0]  disp_data;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [4:0]  wr_row = '0, wr_col = '0;
  logic [7:0]  wr_data = '0;
  logic        clr_start = 1'b0;
  logic        clr_busy;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

`ifdef BOARD_ARB_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  always #5 clk = ~clk;

  board_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .disp_req(disp_req), .disp_row(disp_row), .disp_col(disp_col),
    .disp_gnt(disp_gnt), .disp_valid(disp_valid), .disp_data(disp_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .clr_start(clr_start), .clr_busy(clr_busy), .stall_cnt(stall_cnt)
  );

  task automatic do_read(input logic [4:0] r, input logic [4:0] c,
                         output logic g, output logic v, output logic [7:0] d);
    @(negedge clk);
    disp_req = 1'b1; disp_row = r; disp_col = c;
    #1 g = disp_gnt;
    @(negedge clk);
    v = disp_valid; d = disp_data;
    disp_req = 1'b0;
  endtask

  task automatic do_write(input logic [4:0] r, input logic [4:0] c, input logic [7:0] d);
    @(negedge clk);
    wr_valid = 1'b1; wr_row = r; wr_col = c; wr_data = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic test_reset;
    #1 reset = 1'b0;
    #1;
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL rst_disp_valid: got %b expected 0", disp_valid); end
    checks++; if (disp_data !== 8'd0) begin errors++; $display("FAIL rst_disp_data: got %0d expected 0", disp_data); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rst_wr_ready: got %b expected 1", wr_ready); end
    checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL rst_clr_busy: got %b expected 0", clr_busy); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL rst_stall_cnt: got %0d expected 0", stall_cnt); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL post_rst_wr_ready: got %b expected 1", wr_ready); end
    checks++; if (disp_gnt !== 1'b0) begin errors++; $display("FAIL post_rst_disp_gnt: got %b expected 0", disp_gnt); end
  endtask

  task automatic test_write_read;
    logic g, v; logic [7:0] d;
    do_write(5'd3, 5'd7, 8'd32);
    repeat (2) @(negedge clk);
    do_read(5'd3, 5'd7, g, v, d);
    checks++; if (g !== 1'b1) begin errors++; $display("FAIL wr_rd_gnt: got %b expected 1", g); end
    checks++; if (v !== 1'b1) begin errors++; $display("FAIL wr_rd_valid: got %b expected 1", v); end
    checks++; if (d !== 8'd32) begin errors++; $display("FAIL wr_rd_data: got %0d expected 32", d); end
  endtask

  task automatic test_display_priority;
    int deny_at[$];
    logic rdy3, rdy4;
    logic g, v; logic [7:0] d;
    rdy3 = 1'b0; rdy4 = 1'b1;
    for (int i = 0; i <= 40; i++) begin
      @(negedge clk);
      disp_req = 1'b1; disp_row = 5'd0; disp_col = 5'd0;
      if (i < 4) begin
        wr_valid = 1'b1; wr_row = 5'd1; wr_col = 5'(i); wr_data = 8'(10 + i);
      end else begin
        wr_valid = 1'b0;
      end
      #1;
      if (i == 3) rdy3 = wr_ready;
      if (i == 4) rdy4 = wr_ready;
      if (!disp_gnt) deny_at.push_back(i);
    end
    @(negedge clk);
    disp_req = 1'b0;
    checks++; if (rdy3 !== 1'b1) begin errors++; $display("FAIL prio_ready_c3: got %b expected 1", rdy3); end
    checks++; if (rdy4 !== 1'b0) begin errors++; $display("FAIL prio_ready_c4: got %b expected 0", rdy4); end
    checks++; if (deny_at.size() != 4) begin errors++; $display("FAIL prio_deny_count: got %0d expected 4", deny_at.size()); end
    for (int k = 0; k < deny_at.size() && k < 4; k++) begin
      checks++; if (deny_at[k] != 9 * (k + 1)) begin errors++; $display("FAIL prio_deny_cycle[%0d]: got %0d expected %0d", k, deny_at[k], 9 * (k + 1)); end
    end
    checks++; if (stall_cnt !== 16'(4 * STATS)) begin errors++; $display("FAIL prio_stall_cnt: got %0d expected %0d", stall_cnt, 4 * STATS); end
    do_read(5'd1, 5'd2, g, v, d);
    checks++; if (d !== 8'd12) begin errors++; $display("FAIL prio_data_1_2: got %0d expected 12", d); end
    do_read(5'd1, 5'd3, g, v, d);
    checks++; if (d !== 8'd13) begin errors++; $display("FAIL prio_data_1_3: got %0d expected 13", d); end
  endtask

  task automatic test_fifo_full;
    int acc_at[5];
    int k;
    logic low_c4;
    logic g, v; logic [7:0] d;
    k = 0; low_c4 = 1'b0;
    for (int j = 0; j < 5; j++) acc_at[j] = -1;
    for (int i = 0; i < 40 && k < 5; i++) begin
      @(negedge clk);
      disp_req = 1'b1;
      wr_valid = 1'b1; wr_row = 5'd2; wr_col = 5'(k); wr_data = 8'(20 + k);
      #1;
      if (i == 4) low_c4 = !wr_ready;
      if (wr_ready) begin acc_at[k] = i; k++; end
    end
    @(negedge clk);
    wr_valid = 1'b0;
    checks++; if (acc_at[3] != 3) begin errors++; $display("FAIL full_accept4: got cycle %0d expected 3", acc_at[3]); end
    checks++; if (low_c4 !== 1'b1) begin errors++; $display("FAIL full_ready_low: got %b expected 1", low_c4); end
    checks++; if (acc_at[4] != 10) begin errors++; $display("FAIL full_accept5: got cycle %0d expected 10", acc_at[4]); end
    repeat (60) @(negedge clk);
    disp_req = 1'b0;
    do_read(5'd2, 5'd4, g, v, d);
    checks++; if (d !== 8'd24) begin errors++; $display("FAIL full_data_2_4: got %0d expected 24", d); end
    do_read(5'd2, 5'd0, g, v, d);
    checks++; if (d !== 8'd20) begin errors++; $display("FAIL full_data_2_0: got %0d expected 20", d); end
  endtask

  task automatic test_clear;
    int cnt;
    logic g, v; logic [7:0] d;
    @(negedge clk);
    clr_start = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
    cnt = 0;
    while (clr_busy && cnt < 2000) begin
      cnt++;
      @(negedge clk);
    end
    checks++; if (cnt != 1024) begin errors++; $display("FAIL clr_busy_cycles: got %0d expected 1024", cnt); end
    do_read(5'd3, 5'd7, g, v, d);
    checks++; if (d !== 8'd35) begin errors++; $display("FAIL clr_data_3_7: got %0d expected 35", d); end
    do_read(5'd31, 5'd31, g, v, d);
    checks++; if (d !== 8'd35) begin errors++; $display("FAIL clr_data_31_31: got %0d expected 35", d); end
    do_read(5'd1, 5'd2, g, v, d);
    checks++; if (d !== 8'd35) begin errors++; $display("FAIL clr_data_1_2: got %0d expected 35", d); end
  endtask

  task automatic test_clear_with_write;
    int cnt;
    logic g, v; logic [7:0] d;
    @(negedge clk);
    wr_valid = 1'b1; wr_row = 5'd0; wr_col = 5'd0; wr_data = 8'd77;
    clr_start = 1'b1;
    #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL cw_ready: got %b expected 1", wr_ready); end
    @(negedge clk);
    wr_valid = 1'b0; clr_start = 1'b0;
    checks++; if (clr_busy !== 1'b1) begin errors++; $display("FAIL cw_busy_rise: got %b expected 1", clr_busy); end
    cnt = 0;
    while (clr_busy && cnt < 2000) begin
      cnt++;
      @(negedge clk);
    end
    checks++; if (cnt != 1024) begin errors++; $display("FAIL cw_busy_cycles: got %0d expected 1024", cnt); end
    repeat (2) @(negedge clk);
    do_read(5'd0, 5'd0, g, v, d);
    checks++; if (d !== 8'd77) begin errors++; $display("FAIL cw_data_0_0: got %0d expected 77", d); end
    do_read(5'd0, 5'd1, g, v, d);
    checks++; if (d !== 8'd35) begin errors++; $display("FAIL cw_data_0_1: got %0d expected 35", d); end
  endtask

  task automatic test_reset_mid_clear;
    logic g, v; logic [7:0] d;
    do_write(5'd15, 5'd19, 8'd9);
    do_write(5'd15, 5'd20, 8'd9);
    repeat (3) @(negedge clk);
    @(negedge clk);
    clr_start = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
    repeat (500) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", clr_busy); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL mid_stall_cnt: got %0d expected 0", stall_cnt); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    do_read(5'd15, 5'd19, g, v, d);
    checks++; if (d !== 8'd35) begin errors++; $display("FAIL mid_data_499: got %0d expected 35", d); end
    do_read(5'd15, 5'd20, g, v, d);
    checks++; if (d !== 8'd9) begin errors++; $display("FAIL mid_data_500: got %0d expected 9", d); end
    do_read(5'd0, 5'd0, g, v, d);
    checks++; if (d !== 8'd35) begin errors++; $display("FAIL mid_data_0: got %0d expected 35", d); end
    checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL mid_busy_after: got %b expected 0", clr_busy); end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_display_priority;
    test_fifo_full;
    test_clear;
    test_clear_with_write;
    test_reset_mid_clear;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/board_mem_arbiter.md
# board_mem_arbiter

Arbitrates the single-port 32x32x8 board memory between the LED panel scan reader and the game-logic writer, and sequences full-board clears. The scan reader has priority; a starvation counter guarantees the writer a slot. Writes are buffered in a small FIFO. Sits between game logic and `led_matrix`, replacing the directly shared `board` array.

## Interface
- `MAX_DISP_RUN`, 8: consecutive display grants allowed while a write or clear is pending (1..255).
- `WQ_DEPTH`, 4: write FIFO entries (power of 2, at least 2).
- `CLEAR_CODE`, 8'd35: cell code written by a clear.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `disp_req` in 1: scan reader requests a read this cycle.
- `disp_row` in 5: read row.
- `disp_col` in 5: read column.
- `disp_gnt` out 1: combinational; the read is taken this cycle.
- `disp_valid` out 1: read data valid.
- `disp_data` out 8: cell code.
- `wr_valid` in 1: write offered.
- `wr_ready` out 1: FIFO can accept a write.
- `wr_row` in 5: write row.
- `wr_col` in 5: write column.
- `wr_data` in 8: write cell code.
- `clr_start` in 1: single-cycle pulse that starts a board clear.
- `clr_busy` out 1: a clear is in progress.
- `stall_cnt` out 16: saturating count of display stalls (see Configuration).

## Operation
- Memory address = {row, col}, 10 bits. The memory has synchronous read and write, one access per cycle, and its contents are not reset.
- Write FIFO: a write is accepted when `wr_valid & wr_ready`. `wr_ready = (count < WQ_DEPTH)`, registered, with no same-cycle pass-through when full. Entries drain in order.
- FSM has two states.
  - NORMAL: slot order is display, then FIFO head.
  - CLEAR: slot order is display, then clear sweep. The FIFO still accepts writes but does not drain.
- Transitions:
  - NORMAL to CLEAR on `clr_start`.
  - CLEAR to NORMAL after the write to address 1023.
  - `clr_start` during CLEAR is ignored.
- Clear sweep: `clr_addr` steps 0 to 1023, advancing only on cycles where the sweep owns the slot. There is no wrap-around; the sweep exits at 1023.
- Pending condition:
  - NORMAL: the FIFO is non-empty.
  - CLEAR: always pending.
- Starvation counter `run_cnt`, 8 bits:
  - Increments on each cycle where the display is granted and a write is pending.
  - Clears when nothing is pending, or when the writer or clear sweep takes a slot.
- `disp_gnt = disp_req & ~(pending & run_cnt == MAX_DISP_RUN)`. If the display is denied, the writer or clear sweep takes that slot.
- If `disp_req` is low, a pending write or clear uses the slot.
- Read/write to the same address in different cycles is ordered by slot order; no forwarding is performed.
- Outputs after reset:
  - `disp_valid` = 0, `disp_data` = 0.
  - `wr_ready` = 1, `clr_busy` = 0, `stall_cnt` = 0.
  - FSM is in NORMAL, FIFO is empty, `run_cnt` = 0.
- Reset asserted mid-clear aborts the clear. The board is left partially cleared.

## Timing
- Read latency: `disp_gnt` high in cycle t gives `disp_valid` = 1 and `disp_data` in cycle t+1. `disp_valid` is 0 in every other cycle.
- A write accepted in cycle t can reach memory no earlier than t+1 (FIFO registered).
- `clr_busy` rises the cycle after `clr_start` and falls the cycle after the address-1023 write.
- With no display traffic, a clear takes exactly 1024 cycles.
- With `disp_req` held high, the writer or clear sweep gets 1 slot per `MAX_DISP_RUN+1` cycles.
- A `clr_start` pulse in the same cycle as a write acceptance: the write is queued and drains after the clear completes.

## Configuration
- Macro: `BOARD_ARB_STATS_EN`.
- Defined: `stall_cnt` increments (saturating at 16'hFFFF) on every cycle with `disp_req & ~disp_gnt`.
- Undefined: the counter logic is omitted and `stall_cnt` is tied to 0.

## Structure
- Shared package `board_pkg`:
  - Typedefs `cell_t` (logic [7:0]) and `board_addr_t` (logic [9:0]).
  - Constants `BOARD_DIM` = 32, `CELL_EMPTY` = 8'd35, `CELL_FILLED` = 8'd32.
  - FSM enum `arb_state_t`.
- Sub-module `board_ram`: 1024x8 single-port memory with synchronous read and write. It is instantiated once inside the arbiter.

## Test plan
- Reset, then write (row 3, col 7, 8'd32), then display read of (3,7) with `disp_req` otherwise idle → `disp_valid` next cycle with `disp_data` = 32.
- `disp_req` held high; 4 writes queued → one write drains every 9 cycles; `disp_gnt` low exactly once per 9 cycles.
- 5 writes offered back-to-back with `disp_req` held high → `wr_ready` falls after the 4th write is accepted; the 5th is accepted once the first drains.
- `clr_start` with no display traffic → `clr_busy` high for 1024 cycles; a read of any cell returns 35.
- `clr_start` with a write pending to (0,0) → the clear completes first, then the write lands; a read of (0,0) returns the written value.
- Reset asserted at sweep address 500 → `clr_busy` = 0 immediately; `stall_cnt` = 0 (stats build); cells 0..499 read 35.
